image_conv3x3_stream: RTL and testbench
=======================================

Name: image_conv3x3_stream

Overview:
Parametrised streaming 3x3 convolution filter for raster-order grayscale video, with run-time selectable kernel (pass, sharpen, Gaussian blur, Laplacian edge).
- Uses two line buffers plus a 3x3 window, so no whole-frame storage is needed.
- No padding: emits only interior pixels, giving a (WIDTH-2)x(HEIGHT-2) output stream with frame-end marking.
- Sits between the pixel source and downstream image stages in place of the fixed-kernel sharpener.

Parameters:
WIDTH, 768, active pixels per line (>=3)
HEIGHT, 512, lines per frame (>=3)
PIX_W, 8, bits per pixel (4..12)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
pix_in  in  PIX_W  input pixel, raster order
valid_in  in  1  pix_in valid this cycle; no backpressure
sof_in  in  1  qualifies with valid_in: this pixel is (0,0) of a new frame
mode  in  2  kernel select: 0 pass, 1 sharpen, 2 gauss, 3 edge
pix_out  out  PIX_W  filtered pixel
valid_out  out  1  pix_out valid
eof_out  out  1  with valid_out: last output pixel of frame

Behaviour:
- Reset (reset_n low, async): pix_out=0, valid_out=0, eof_out=0, x=y=0, active mode=0, pipeline valids cleared. Line-buffer contents are not reset (don't care).
- Counters:
  - x in 0..WIDTH-1, y in 0..HEIGHT-1; advance only on valid_in.
  - x wraps to 0 and y increments; after (WIDTH-1,HEIGHT-1) both wrap to 0.
  - valid_in&&sof_in forces the accepted pixel to be (0,0) regardless of counter state (resync mid-frame allowed). Pixels already in the pipeline still drain.
- Mode latch: mode is sampled into the active-mode register on a valid_in&&sof_in beat and applies from that frame's first output. Mid-frame mode changes are ignored.
- Window: on each valid_in the window shifts left one column. The new column is {line0[x], line1[x], pix_in}; line0[x]<=line1[x], line1[x]<=pix_in.
- Output rule: accepting pixel (x,y) with x>=2 and y>=2 produces the output for centre (x-1,y-1). Other positions produce no output, so stale window columns at line start are harmless.
- Pipeline and latency:
  - 2 stages: stage 1 = window register + kernel sum; stage 2 = normalise/clamp into pix_out.
  - valid_out rises exactly 2 cycles after the qualifying valid_in edge.
  - The pipeline advances every cycle. valid_in gaps give matching valid_out gaps, with latency unchanged.
  - valid_out is low on cycles with no qualifying input; pix_out holds its last value.
- Kernels (c=centre, n4=sum of 4-neighbours, d4=sum of diagonals):
  - pass: c.
  - sharpen: 5c - n4, signed width PIX_W+4, clamp to [0, 2^PIX_W-1].
  - gauss: (4c + 2*n4 + d4 + 8) >> 4, unsigned width PIX_W+5; result never exceeds max.
  - edge: |4c - n4|, clamp to max.
- eof_out is asserted with the output for centre (WIDTH-2,HEIGHT-2) and is never asserted without valid_out.
- Reset mid-frame: pipeline is flushed, no partial outputs emitted. The next frame must start with sof_in, or at counters (0,0).

Decomposition:
- Package image_conv_pkg: mode enum (MODE_PASS, MODE_SHARP, MODE_GAUSS, MODE_EDGE), kernel coefficient constants, and width-helper functions (clamp, sum width from PIX_W).
- Sub-module image_line_buffer: WIDTH-deep by PIX_W dual line memory with one write and one read per valid_in at address x. Maps to simple dual-port RAM.

Test Plan:
- WIDTH=5, HEIGHT=4, pass, ramp pix=y*5+x, continuous valid: 6 outputs 6,7,8,11,12,13 -> each 2 cycles after inputs (2,2)..(4,3); eof_out on 13 only.
- Sharpen, constant 100 frame -> every output 100. Impulse 100 at (2,2) in zero frame -> (2,2)=255 (clamped 500), (1,2),(3,2),(2,1),(2,3)=0 (clamped -100), others 0.
- Gauss, impulse 160 at (2,2) -> centre 40, edge neighbours 20, diagonals 10. Edge, impulse 50 -> centre 200, 4-neighbours 50, diagonals 0.
- Random valid_in gaps (~50% duty), ramp in pass mode -> identical value sequence to gapless run; each valid_out exactly 2 cycles after its qualifying input.
- Mode changed 0->1 mid-frame -> remainder of frame still pass. sof_in with mode=1 -> next frame sharpened from first output.
- reset_n low mid-frame for 1 cycle -> outputs cleared asynchronously with no stray valid_out. sof_in asserted at counter (3,1) -> counters resync, next frame's output count is exactly (WIDTH-2)*(HEIGHT-2).

Source files
------------

// File: rtl/image_conv3x3_stream_pkg.sv
// Shared types and helpers for the streaming 3x3 convolution filter.
// Kernel selector, coefficient constants and width/clamp helpers.
package image_conv_pkg;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_SHARP = 2'd1,
        MODE_GAUSS = 2'd2,
        MODE_EDGE  = 2'd3
    } mode_e;

    localparam int SHARP_C   = 5;
    localparam int EDGE_C    = 4;
    localparam int GAUSS_C   = 4;
    localparam int GAUSS_N   = 2;
    localparam int GAUSS_RND = 8;
    localparam int GAUSS_SH  = 4;

    // Signed width that holds every kernel's raw sum, incl. gauss pre-shift.
    function automatic int sum_w(input int pix_w);
        return pix_w + 6;
    endfunction

    function automatic int clamp_int(input int v, input int pix_w);
        int mx;
        mx = (1 << pix_w) - 1;
        if (v < 0) return 0;
        if (v > mx) return mx;
        return v;
    endfunction

endpackage

// File: rtl/image_conv3x3_stream_if.sv
// Pixel stream bundle between source, filter and downstream stage.
// master = source/sink side, slave = filter side.
interface image_conv3x3_stream_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0] pix_in;
    logic             valid_in;
    logic             sof_in;
    logic [1:0]       mode;
    logic [PIX_W-1:0] pix_out;
    logic             valid_out;
    logic             eof_out;

    modport master (
        output pix_in, valid_in, sof_in, mode,
        input  pix_out, valid_out, eof_out
    );

    modport slave (
        input  pix_in, valid_in, sof_in, mode,
        output pix_out, valid_out, eof_out
    );
endinterface

// File: rtl/image_line_buffer.sv
// Two WIDTH-deep line memories; one read and one write per accepted pixel.
// line0 holds row y-2, line1 row y-1 at the current column.
module image_line_buffer #(
    parameter int WIDTH = 768,
    parameter int PIX_W = 8,
    parameter int XW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [XW-1:0]    addr_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] top_o,
    output logic [PIX_W-1:0] mid_o
);
    logic [PIX_W-1:0] line0_q [WIDTH];
    logic [PIX_W-1:0] line1_q [WIDTH];

    assign top_o = line0_q[addr_i];
    assign mid_o = line1_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            line0_q[addr_i] <= line1_q[addr_i];
            line1_q[addr_i] <= din_i;
        end
    end
endmodule

// File: rtl/image_conv3x3_stream.sv
// Streaming 3x3 convolution, interior pixels only, run-time kernel select.
// Window+sum stage, then normalise/clamp stage; output 2 cycles after input.
module image_conv3x3_stream
    import image_conv_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int PIX_W  = 8
) (
    input logic clk,
    input logic reset_n,
    image_conv3x3_stream_if.slave io
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int SW = sum_w(PIX_W);

    typedef logic signed [SW-1:0] sum_t;

    localparam sum_t K_SHARP = sum_t'(SHARP_C);
    localparam sum_t K_EDGE  = sum_t'(EDGE_C);
    localparam sum_t K_GC    = sum_t'(GAUSS_C);
    localparam sum_t K_GN    = sum_t'(GAUSS_N);
    localparam sum_t K_RND   = sum_t'(GAUSS_RND);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0]    x_q, x_d, x_cur;
    logic [YW-1:0]    y_q, y_d, y_cur;
    mode_e            mode_q, mode_d, mode_cur;
    logic             qual, last;
    logic [PIX_W-1:0] top_pix, mid_pix;
    logic [PIX_W-1:0] win_q [3][3];
    logic             v0_q, eof0_q;
    mode_e            md0_q;
    sum_t             c, n4, d4, t, sum_d, sum_q;
    logic             v1_q, eof1_q;
    logic [PIX_W-1:0] pix_d, pix_q;
    logic             vout_q, eof_q;

    function automatic sum_t ext(input logic [PIX_W-1:0] p);
        return sum_t'(p);
    endfunction

    // sof forces the accepted pixel to (0,0) and latches the frame's kernel
    always_comb begin
        x_cur    = io.sof_in ? '0 : x_q;
        y_cur    = io.sof_in ? '0 : y_q;
        mode_cur = io.sof_in ? mode_e'(io.mode) : mode_q;
        x_d      = x_q;
        y_d      = y_q;
        mode_d   = mode_q;
        if (io.valid_in) begin
            mode_d = mode_cur;
            x_d    = (x_cur == X_LAST) ? '0 : x_cur + 1'b1;
            y_d    = y_cur;
            if (x_cur == X_LAST)
                y_d = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
        end
    end

    assign qual = io.valid_in && (x_cur >= XW'(2)) && (y_cur >= YW'(2));
    assign last = (x_cur == X_LAST) && (y_cur == Y_LAST);

    image_line_buffer #(
        .WIDTH (WIDTH),
        .PIX_W (PIX_W),
        .XW    (XW)
    ) u_lb (
        .clk    (clk),
        .we_i   (io.valid_in),
        .addr_i (x_cur),
        .din_i  (io.pix_in),
        .top_o  (top_pix),
        .mid_o  (mid_pix)
    );

    always_comb begin
        c  = ext(win_q[1][1]);
        n4 = ext(win_q[0][1]) + ext(win_q[2][1])
           + ext(win_q[1][0]) + ext(win_q[1][2]);
        d4 = ext(win_q[0][0]) + ext(win_q[0][2])
           + ext(win_q[2][0]) + ext(win_q[2][2]);
        t     = K_EDGE * c - n4;
        sum_d = c;
        unique case (md0_q)
            MODE_PASS:  sum_d = c;
            MODE_SHARP: sum_d = K_SHARP * c - n4;
            MODE_GAUSS: sum_d = (K_GC * c + K_GN * n4 + d4 + K_RND) >>> GAUSS_SH;
            MODE_EDGE:  sum_d = t[SW-1] ? -t : t;
        endcase
    end

    assign pix_d = PIX_W'(clamp_int(int'(sum_q), PIX_W));

    always_ff @(posedge clk) begin
        if (io.valid_in) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= top_pix;
            win_q[1][2] <= mid_pix;
            win_q[2][2] <= io.pix_in;
        end
        sum_q <= sum_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= MODE_PASS;
            v0_q   <= 1'b0;
            eof0_q <= 1'b0;
            md0_q  <= MODE_PASS;
            v1_q   <= 1'b0;
            eof1_q <= 1'b0;
            pix_q  <= '0;
            vout_q <= 1'b0;
            eof_q  <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            mode_q <= mode_d;
            v0_q   <= qual;
            eof0_q <= qual && last;
            md0_q  <= mode_cur;
            v1_q   <= v0_q;
            eof1_q <= eof0_q;
            vout_q <= v1_q;
            eof_q  <= eof1_q;
            if (v1_q) pix_q <= pix_d;
        end
    end

    assign io.pix_out   = pix_q;
    assign io.valid_out = vout_q;
    assign io.eof_out   = eof_q;
endmodule

// File: tb/tb_image_conv3x3_stream.sv
// Scoreboard bench for image_conv3x3_stream on a 5x4 frame.
// Expected pixels come from a whole-frame arithmetic model.
module tb_image_conv3x3_stream;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int PW   = 8;
    localparam int MAXV = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    image_conv3x3_stream_if #(.PIX_W(PW)) io ();

    image_conv3x3_stream #(
        .WIDTH  (W),
        .HEIGHT (H),
        .PIX_W  (PW)
    ) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .io      (io.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     pix;
        bit     eof;
        longint cyc;
    } exp_t;

    exp_t   sbq[$];
    int     seen[$];
    int     img [H][W];
    int     n_chk    = 0;
    int     n_fail   = 0;
    int     lat_mode = 0;
    longint cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input longint req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int ref_pix(input int cx, input int cy, input int m);
        int cc, nn, dd, r;
        cc = img[cy][cx];
        nn = img[cy-1][cx] + img[cy+1][cx] + img[cy][cx-1] + img[cy][cx+1];
        dd = img[cy-1][cx-1] + img[cy-1][cx+1]
           + img[cy+1][cx-1] + img[cy+1][cx+1];
        case (m)
            0:       r = cc;
            1:       r = 5 * cc - nn;
            2:       r = (4 * cc + 2 * nn + dd + 8) / 16;
            default: r = (4 * cc >= nn) ? 4 * cc - nn : nn - 4 * cc;
        endcase
        if (r < 0) r = 0;
        if (r > MAXV) r = MAXV;
        return r;
    endfunction

    // Monitor: every valid_out pops one expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!io.valid_out) begin
            check("eof_idle", io.eof_out, 0);
        end else if (sbq.size() == 0) begin
            check("stray_valid", io.valid_out, 0);
        end else begin
            e = sbq.pop_front();
            seen.push_back(int'(io.pix_out));
            check("pix", io.pix_out, e.pix);
            check("eof", io.eof_out, e.eof);
            check("latency", cyc, e.cyc);
        end
    end

    task automatic make_img(input int kind, input int val);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (kind)
                    0:       img[y][x] = y * W + x;
                    1:       img[y][x] = val;
                    2:       img[y][x] = (x == 2 && y == 2) ? val : 0;
                    default: img[y][x] = int'($urandom_range(MAXV));
                endcase
    endtask

    task automatic idle();
        @(negedge clk);
        io.valid_in = 1'b0;
        io.sof_in   = 1'b0;
        io.pix_in   = PW'($urandom);
    endtask

    task automatic send_px(input int x, input int y, input bit sof,
                           input int m, input int gap);
        while (int'($urandom_range(99)) < gap) idle();
        @(negedge clk);
        io.valid_in = 1'b1;
        io.sof_in   = sof;
        io.mode     = 2'(m);
        io.pix_in   = PW'(img[y][x]);
        if (sof) lat_mode = m;
        if (x >= 2 && y >= 2)
            sbq.push_back('{ref_pix(x - 1, y - 1, lat_mode),
                            (x == W - 1 && y == H - 1), cyc + 3});
    endtask

    task automatic send_frame(input int m_sof, input int m_mid,
                              input int gap, input int npix);
        for (int k = 0; k < npix; k++)
            send_px(k % W, k / W, k == 0, (k == 0) ? m_sof : m_mid, gap);
        idle();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", sbq.size(), 0);
    endtask

    task automatic check_ramp(input string name);
        int golden[6] = '{6, 7, 8, 11, 12, 13};
        check({name, "_count"}, seen.size(), 6);
        for (int i = 0; i < 6 && i < seen.size(); i++)
            check(name, seen[i], golden[i]);
    endtask

    initial begin
        io.valid_in = 1'b0;
        io.sof_in   = 1'b0;
        io.mode     = 2'd0;
        io.pix_in   = '0;
        #2;
        check("reset_valid", io.valid_out, 0);
        check("reset_eof", io.eof_out, 0);
        check("reset_pix", io.pix_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        make_img(0, 0);
        seen.delete();
        send_frame(0, 0, 0, W * H);
        wait_drain();
        check_ramp("ramp_gapless");

        make_img(1, 100);
        send_frame(1, 1, 0, W * H);
        make_img(2, 100);
        send_frame(1, 1, 0, W * H);
        make_img(2, 160);
        send_frame(2, 2, 0, W * H);
        make_img(2, 50);
        send_frame(3, 3, 0, W * H);
        wait_drain();

        make_img(0, 0);
        seen.delete();
        send_frame(0, 2, 50, W * H);
        wait_drain();
        check_ramp("ramp_gapped");

        make_img(3, 0);
        send_frame(0, 1, 0, W * H);
        make_img(3, 0);
        send_frame(1, 0, 0, W * H);

        for (int i = 0; i < 8; i++) begin
            make_img(3, 0);
            send_frame(int'($urandom_range(3)), int'($urandom_range(3)),
                       30, W * H);
        end
        wait_drain();

        make_img(3, 0);
        send_frame(2, 2, 0, W + 3);
        make_img(3, 0);
        send_frame(1, 1, 20, W * H);
        wait_drain();

        make_img(3, 0);
        send_frame(3, 3, 0, 3 * W + 3);
        make_img(3, 0);
        send_frame(2, 2, 0, W * H);
        wait_drain();

        make_img(3, 0);
        for (int k = 0; k < 2 * W + 5; k++)
            send_px(k % W, k / W, k == 0, 1, 0);
        @(posedge clk);
        #1;
        io.valid_in = 1'b0;
        io.sof_in   = 1'b0;
        rst_n       = 1'b0;
        #1;
        check("midrst_valid", io.valid_out, 0);
        check("midrst_eof", io.eof_out, 0);
        check("midrst_pix", io.pix_out, 0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) idle();
        make_img(3, 0);
        send_frame(3, 0, 10, W * H);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
